// File: rtl/trigger_word.sv
// trigger_word: multi-bit debug trigger with per-bit modes, AND/OR combine,
// a consecutive-match threshold and a two-stage aligned data pass-through.
//
// Optional feature macro: TRIGGER_WORD_AUTO_REARM_EN
//   undefined: after a trigger the FSM parks in DONE until the next arm.
//   defined:   DONE becomes HOLDOFF; the FSM re-arms itself after
//              holdoff_cycles cycles (or at once on arm).
//
// Ports:
//   clk                  single clock
//   rst_n                synchronous reset, ACTIVE-HIGH despite the name
//   arm                  single-cycle arm/restart request
//   trigger_pattern      compare pattern for match/mismatch modes
//   trigger_mode         3 bits per data bit: 000 mask, 001 match,
//                        010 mismatch, 011 rising, 100 falling,
//                        101 both edges, 110/111 reserved (never hit)
//   combine_op           0 = AND of unmasked bits, 1 = OR of unmasked bits
//   match_cnt_thr        consecutive hits required (0 behaves as 1)
//   holdoff_cycles       re-arm delay (auto-rearm build only)
//   trigger_data(_vld)   input sample stream
//   trigger_hit          registered combined hit for the aligned sample
//   trigger_succeed      one-cycle trigger pulse
//   trigger_armed        high while the FSM is ARMED
//   trigger_data_out(_vld) input stream delayed by 2 cycles
module trigger_word #(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 8,
    parameter int HOLDOFF_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic [WIDTH-1:0]     trigger_pattern,
    input  logic [3*WIDTH-1:0]   trigger_mode,
    input  logic                 combine_op,
    input  logic [CNT_W-1:0]     match_cnt_thr,
    input  logic [HOLDOFF_W-1:0] holdoff_cycles,
    input  logic [WIDTH-1:0]     trigger_data,
    input  logic                 trigger_data_vld,
    output logic                 trigger_hit,
    output logic                 trigger_succeed,
    output logic                 trigger_armed,
    output logic [WIDTH-1:0]     trigger_data_out,
    output logic                 trigger_data_out_vld
);

`ifdef TRIGGER_WORD_AUTO_REARM_EN
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HOLDOFF} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;
`endif

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_d1, r_prev;
    logic             r_d1_vld;
    logic [WIDTH-1:0] w_bit_hit, w_bit_care;
    logic             w_comb, w_hit, w_fire, w_terminal;
    logic [CNT_W:0]   w_cnt_p1;
    logic [CNT_W-1:0] w_cnt_sat, w_thr_eff;

`ifdef TRIGGER_WORD_AUTO_REARM_EN
    logic [HOLDOFF_W-1:0] r_hold, w_hold_nxt;
`else
    logic w_unused_holdoff;
    assign w_unused_holdoff = ^holdoff_cycles;
`endif

    // Edges compare the sample in d1 with the last *valid* sample, so invalid
    // gaps neither create nor hide an edge.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [2:0] w_mode;
        assign w_mode        = trigger_mode[3*i +: 3];
        assign w_bit_care[i] = |w_mode;
        assign w_bit_hit[i]  = (w_mode == 3'b001) ? (r_d1[i] == trigger_pattern[i]) :
                               (w_mode == 3'b010) ? (r_d1[i] != trigger_pattern[i]) :
                               (w_mode == 3'b011) ? (!r_prev[i] && r_d1[i])         :
                               (w_mode == 3'b100) ? (r_prev[i] && !r_d1[i])         :
                               (w_mode == 3'b101) ? (r_prev[i] != r_d1[i])          : 1'b0;
    end

    // A fully masked word always hits; reserved modes count as unmasked misses.
    assign w_comb = ~|w_bit_care | (combine_op ? |(w_bit_hit & w_bit_care)
                                               : &(w_bit_hit | ~w_bit_care));
    assign w_hit  = w_comb & r_d1_vld;

    // Compare count+1 one bit wider so the comparison itself never wraps.
    assign w_thr_eff  = (match_cnt_thr == '0) ? CNT_W'(1) : match_cnt_thr;
    assign w_cnt_p1   = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_terminal = w_cnt_p1 >= {1'b0, w_thr_eff};
    assign w_cnt_sat  = (&r_cnt) ? r_cnt : w_cnt_p1[CNT_W-1:0];

    // A terminal hit takes priority over a simultaneous arm.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
`ifdef TRIGGER_WORD_AUTO_REARM_EN
        w_hold_nxt  = r_hold;
`endif
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_state_nxt = S_ARMED;
                    w_cnt_nxt   = '0;
                end
            end
            S_ARMED: begin
                if (w_hit && w_terminal) begin
                    w_fire    = 1'b1;
                    w_cnt_nxt = '0;
`ifdef TRIGGER_WORD_AUTO_REARM_EN
                    w_state_nxt = S_HOLDOFF;
                    w_hold_nxt  = holdoff_cycles;
`else
                    w_state_nxt = S_DONE;
`endif
                end else if (arm) begin
                    w_cnt_nxt = '0;
                end else if (r_d1_vld) begin
                    w_cnt_nxt = w_hit ? w_cnt_sat : '0;
                end
            end
`ifdef TRIGGER_WORD_AUTO_REARM_EN
            S_HOLDOFF: begin
                if (arm || r_hold == '0) begin
                    w_state_nxt = S_ARMED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_hold_nxt = r_hold - HOLDOFF_W'(1);
                end
            end
`else
            S_DONE: begin
                if (arm) begin
                    w_state_nxt = S_ARMED;
                    w_cnt_nxt   = '0;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state              <= S_IDLE;
            r_cnt                <= '0;
            r_d1                 <= '0;
            r_d1_vld             <= 1'b0;
            r_prev               <= '0;
            trigger_hit          <= 1'b0;
            trigger_succeed      <= 1'b0;
            trigger_armed        <= 1'b0;
            trigger_data_out     <= '0;
            trigger_data_out_vld <= 1'b0;
        end else begin
            r_state              <= w_state_nxt;
            r_cnt                <= w_cnt_nxt;
            r_d1                 <= trigger_data;
            r_d1_vld             <= trigger_data_vld;
            r_prev               <= r_d1_vld ? r_d1 : r_prev;
            trigger_hit          <= w_hit;
            trigger_succeed      <= w_fire;
            trigger_armed        <= (w_state_nxt == S_ARMED);
            trigger_data_out     <= r_d1;
            trigger_data_out_vld <= r_d1_vld;
        end
    end

`ifdef TRIGGER_WORD_AUTO_REARM_EN
    always_ff @(posedge clk) begin
        if (rst_n) r_hold <= '0;
        else       r_hold <= w_hold_nxt;
    end
`endif

endmodule

// File: tb/tb_trigger_word.sv
// tb_trigger_word: scoreboard bench for trigger_word (WIDTH = 4).
module tb_trigger_word;
    localparam int W  = 4;
    localparam int CW = 8;
    localparam int HW = 8;

    logic          clk = 1'b0, rst_n = 1'b1, arm = 1'b0, combine_op = 1'b0;
    logic [W-1:0]  trigger_pattern = '0, trigger_data = '0;
    logic [3*W-1:0] trigger_mode = '0;
    logic [CW-1:0] match_cnt_thr = 8'd1;
    logic [HW-1:0] holdoff_cycles = 8'd5;
    logic          trigger_data_vld = 1'b0;
    logic          trigger_hit, trigger_succeed, trigger_armed, trigger_data_out_vld;
    logic [W-1:0]  trigger_data_out;

    trigger_word #(.WIDTH(W), .CNT_W(CW), .HOLDOFF_W(HW)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm),
        .trigger_pattern(trigger_pattern), .trigger_mode(trigger_mode),
        .combine_op(combine_op), .match_cnt_thr(match_cnt_thr),
        .holdoff_cycles(holdoff_cycles), .trigger_data(trigger_data),
        .trigger_data_vld(trigger_data_vld), .trigger_hit(trigger_hit),
        .trigger_succeed(trigger_succeed), .trigger_armed(trigger_armed),
        .trigger_data_out(trigger_data_out), .trigger_data_out_vld(trigger_data_out_vld)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         hit;
        logic         succ;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every valid output pops one expected {data,hit,succeed};
    // cycles without a valid output must show no hit and no pulse.
    always @(negedge clk) begin
        if (trigger_data_out_vld === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_out: data %0h hit %0b succ %0b with nothing expected",
                         trigger_data_out, trigger_hit, trigger_succeed);
            end else begin
                m_e = q.pop_front();
                chk("sample{data,hit,succ}", {trigger_data_out, trigger_hit, trigger_succeed}, m_e);
            end
        end else begin
            chk("quiet{hit,succ}", {trigger_hit, trigger_succeed}, 2'b00);
        end
    end

    task automatic cyc(input logic [W-1:0] d, input logic v, input logic a,
                       input logic eh, input logic es);
        @(posedge clk);
        #1;
        trigger_data     = d;
        trigger_data_vld = v;
        arm              = a;
        if (v) q.push_back(exp_t'({d, eh, es}));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        trigger_data_vld = 1'b0;
        arm              = 1'b0;
        rst_n            = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        rst_n = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hit"}, trigger_hit, 0);
        chk({tag, "_succ"}, trigger_succeed, 0);
        chk({tag, "_armed"}, trigger_armed, 0);
        chk({tag, "_data_out"}, trigger_data_out, 0);
        chk({tag, "_data_out_vld"}, trigger_data_out_vld, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic es;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b0;

        // Match, AND, thr 1: hit and pulse two cycles after the sample.
        trigger_mode = 12'h249; trigger_pattern = 4'hA; combine_op = 1'b0; match_cnt_thr = 8'd1;
        cyc(4'h0, 0, 1, 0, 0);
        cyc(4'hA, 1, 0, 1, 1);
        chk("armed_after_arm", trigger_armed, 1);
        cyc(4'hA, 1, 0, 1, 0);
        cyc(4'h5, 1, 0, 0, 0);
        idle(3);
        chk("not_armed_after_fire", trigger_armed, 0);

        // Reset mid-stream with the counter at 2 and a sample in flight.
        match_cnt_thr = 8'd5;
        cyc(4'h0, 0, 1, 0, 0);
        cyc(4'hA, 1, 0, 1, 0);
        cyc(4'hA, 1, 0, 1, 0);
        idle(1);
        chk("armed_before_reset", trigger_armed, 1);
        cyc(4'hA, 1, 0, 1, 0);
        do_reset();
        chk_zero("midreset");
        match_cnt_thr = 8'd1;
        cyc(4'hA, 1, 0, 1, 0);
        idle(2);
        chk("idle_ignores_hits", trigger_armed, 0);

        // Rising edge on bit0 measured across invalid gaps.
        trigger_mode = 12'h003;
        cyc(4'h0, 1, 0, 0, 0);
        cyc(4'h1, 0, 0, 0, 0);
        cyc(4'h1, 0, 0, 0, 0);
        cyc(4'h1, 0, 0, 0, 0);
        cyc(4'h1, 1, 0, 1, 0);
        cyc(4'h1, 1, 0, 0, 0);
        cyc(4'h0, 0, 0, 0, 0);
        cyc(4'h0, 0, 0, 0, 0);
        cyc(4'h1, 1, 0, 0, 0);
        cyc(4'h0, 1, 0, 0, 0);
        cyc(4'h1, 1, 0, 1, 0);
        idle(2);

        // OR: bit0 match 1, bit1 falling, thr 3.
        trigger_mode = 12'h021; trigger_pattern = 4'h1; combine_op = 1'b1; match_cnt_thr = 8'd3;
        cyc(4'h0, 0, 1, 0, 0);
        cyc(4'h1, 1, 0, 1, 0);
        cyc(4'h1, 1, 0, 1, 0);
        cyc(4'h1, 1, 0, 1, 1);
        idle(2);
        cyc(4'h0, 0, 1, 0, 0);
        cyc(4'h1, 1, 0, 1, 0);
        cyc(4'h1, 1, 0, 1, 0);
        cyc(4'h0, 1, 0, 0, 0);
        cyc(4'h1, 1, 0, 1, 0);
        cyc(4'h2, 1, 0, 0, 0);
        cyc(4'h0, 1, 0, 1, 0);
        cyc(4'h1, 1, 0, 1, 0);
        cyc(4'h1, 1, 0, 1, 1);
        idle(2);
        // Invalid cycle holds the count.
        cyc(4'h0, 0, 1, 0, 0);
        cyc(4'h1, 1, 0, 1, 0);
        cyc(4'h1, 1, 0, 1, 0);
        cyc(4'h0, 0, 0, 0, 0);
        cyc(4'h1, 1, 0, 1, 1);
        idle(2);
        // Threshold 0 behaves as 1.
        match_cnt_thr = 8'd0;
        cyc(4'h0, 0, 1, 0, 0);
        cyc(4'h1, 1, 0, 1, 1);
        idle(2);
        // Arm while ARMED clears the count.
        match_cnt_thr = 8'd3;
        cyc(4'h0, 0, 1, 0, 0);
        cyc(4'h1, 1, 0, 1, 0);
        cyc(4'h1, 1, 0, 1, 0);
        idle(1);
        cyc(4'h0, 0, 1, 0, 0);
        cyc(4'h1, 1, 0, 1, 0);
        cyc(4'h1, 1, 0, 1, 0);
        cyc(4'h1, 1, 0, 1, 1);
        idle(2);
        // Arm on the same edge as a terminal hit is ignored.
        match_cnt_thr = 8'd1;
        cyc(4'h0, 0, 1, 0, 0);
        cyc(4'h1, 1, 0, 1, 1);
        cyc(4'h0, 0, 1, 0, 0);
        cyc(4'h1, 1, 0, 1, 0);
        idle(2);
        chk("arm_ignored_on_fire", trigger_armed, 0);

        // All masked always hits; a reserved bit never hits.
        do_reset();
        trigger_mode = 12'h000; combine_op = 1'b0;
        cyc(4'h5, 1, 0, 1, 0);
        cyc(4'h0, 1, 0, 1, 0);
        idle(2);
        combine_op = 1'b1;
        cyc(4'hF, 1, 0, 1, 0);
        idle(2);
        trigger_mode = 12'h180; combine_op = 1'b0;
        cyc(4'h4, 1, 0, 0, 0);
        cyc(4'hF, 1, 0, 0, 0);
        cyc(4'h0, 1, 0, 0, 0);
        idle(2);
        combine_op = 1'b1;
        cyc(4'h4, 1, 0, 0, 0);
        idle(2);

        // Continuous hits after a single arm.
        trigger_mode = 12'h249; trigger_pattern = 4'hA; combine_op = 1'b0; match_cnt_thr = 8'd1;
        cyc(4'h0, 0, 1, 0, 0);
        for (int k = 0; k < 16; k++) begin
`ifdef TRIGGER_WORD_AUTO_REARM_EN
            es = (k % 7 == 0);
`else
            es = (k == 0);
`endif
            cyc(4'hA, 1, 0, 1, es);
        end
        idle(3);
`ifndef TRIGGER_WORD_AUTO_REARM_EN
        chk("done_sticky", trigger_armed, 0);
`endif
        cyc(4'h0, 0, 1, 0, 0);
        cyc(4'hA, 1, 0, 1, 1);
        idle(4);

        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        chk("drain_left", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
